ucode_seq: RTL and testbench
============================

UCODE_SEQ -- requirements
Module: ucode_seq

Interface
REQ-001 SHALL have parameter IMM_W, default 16, meaning the width of the repeat count (legal range 1..16).
REQ-002 SHALL have parameter INSTR_W, default 32, meaning the instruction width (fixed at 32 by the ISA).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port start_valid, input, 1 bit: the decoder presents a macro-op.
REQ-006 SHALL have port start_ready, output, 1 bit: the sequencer accepts a macro-op this cycle.
REQ-007 SHALL have port op_sel, input, 2 bits: 00 MUL, 01 MAC, 10 CLR, 11 reserved.
REQ-008 SHALL have port dest_reg, input, 4 bits: Rd address.
REQ-009 SHALL have port source_reg, input, 4 bits: Rs address.
REQ-010 SHALL have port immediate, input, IMM_W bits: the repeat count.
REQ-011 SHALL have port out_instr, output, 32 bits: the generated instruction.
REQ-012 SHALL have port out_valid, output, 1 bit: out_instr is valid.
REQ-013 SHALL have port out_ready, input, 1 bit: the pipeline accepts out_instr; low means stall.
REQ-014 SHALL have port busy, output, 1 bit: high in every state other than IDLE.
REQ-015 SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-016 SHALL have port err, output, 1 bit: qualifies done for a reserved op.
REQ-017 SHALL have port abort, input, 1 bit: flushes the sequence (active only per REQ-036).

Function
REQ-018 SHALL use states IDLE, CLR, MOV, ADD, FIN.
REQ-019 SHALL drive start_ready = (state==IDLE) and accept on start_valid&&start_ready.
REQ-020 SHALL latch op_sel, dest_reg, source_reg and immediate on accept; later input changes have no effect.
REQ-021 SHALL, on accept: MUL imm=0 -> CLR; MUL imm>0 -> MOV; MAC imm>0 -> ADD; MAC imm=0, CLR op or reserved op -> FIN.
REQ-022 SHALL load the counter with immediate on accept, counting ADD issues down to zero.
REQ-023 SHALL emit {SUB,Rd,Rd,Rd,13'b0} in CLR and go to FIN on handshake.
REQ-024 SHALL emit {MOV,Rd,5'b0,16'b0} in MOV and go to ADD on handshake.
REQ-025 SHALL emit {ADD,Rd,Rd,Rs,13'b0} in ADD, decrement the counter on each handshake, and go to FIN on the handshake where the counter is 1.
REQ-026 SHALL treat op CLR like MUL imm=0 (one SUB Rd,Rd,Rd), overriding REQ-021 for that op.
REQ-027 SHALL assert out_valid in CLR, MOV and ADD only, and advance state or counter only on out_valid&&out_ready.
REQ-028 SHALL hold out_instr stable while out_valid=1 and out_ready=0.
REQ-029 SHALL drive out_instr = NOP ({5'b11001,27'b0}) whenever out_valid=0.
REQ-030 SHALL pulse done for exactly one cycle in FIN, with err=1 only for the reserved op, then return to IDLE.
REQ-031 SHALL give one cycle of latency from accept to first out_valid.
REQ-032 SHALL complete MUL imm=N with out_ready held high in N+1 instructions, done at accept+N+2, and start_ready at accept+N+3.
REQ-033 SHALL keep start_ready low in FIN, so start_valid asserted there waits until IDLE.
REQ-034 SHALL support IMM_W=16, immediate=16'hFFFF, giving 65535 ADDs with no counter wrap.

Reset
REQ-035 SHALL, when rst_n is low, immediately force state IDLE, counter 0, out_valid 0, out_instr NOP, busy 0, done 0 and err 0 (start_ready 1), including mid-sequence, with no done pulse.

Configuration
REQ-036 SHALL, with UCODE_ABORT_EN defined, force the state to IDLE on the next edge when abort=1 in any state, driving out_valid=0 that same cycle and issuing no done pulse; abort outranks the handshake.
REQ-037 SHALL, with UCODE_ABORT_EN undefined, keep the abort port present but ignore it.

Structure
REQ-038 SHALL place the opcodes (MOV 7'b0000000, ADD 7'b0110001, SUB 7'b0110010), the NOP word, the op_sel encodings, the state encoding and the instruction-format functions in package ucode_pkg.
REQ-039 SHALL be implemented as a single module with no sub-module.

Verification
REQ-040 Bench SHALL check: MUL Rd=1, Rs=0, imm=3, out_ready=1 -> MOV R1,#0 then 3x ADD R1,R1,R0; done at accept+5; err=0.
REQ-041 Bench SHALL check: MUL imm=0 -> one SUB R1,R1,R1 then done; CLR op gives the same; MAC imm=0 -> no out_valid, done at accept+1.
REQ-042 Bench SHALL check: MAC Rd=2, Rs=3, imm=2, with out_ready low for 3 cycles on the first ADD -> ADD R2,R2,R3 held stable, exactly 2 ADDs issued.
REQ-043 Bench SHALL check: reserved op=11 -> no instructions, done=1 with err=1 for one cycle.
REQ-044 Bench SHALL check: rst_n low during the 2nd ADD of imm=5 -> out_valid=0 and out_instr=NOP immediately, start_ready=1, no done.
REQ-045 Bench SHALL check, with UCODE_ABORT_EN: abort during MOV -> IDLE next cycle with no done; without the macro the same stimulus completes normally.

Source files
------------

// File: rtl/ucode_pkg.sv
// ucode_pkg -- shared definitions for the microcode sequencer.
//   * opcode fields and the NOP word of the target ISA
//   * macro-op encodings carried on op_sel
//   * sequencer state encoding
//   * instruction-format helpers (SUB / MOV / ADD)
package ucode_pkg;

  localparam logic [6:0]  OPC_MOV   = 7'b0000000;
  localparam logic [6:0]  OPC_ADD   = 7'b0110001;
  localparam logic [6:0]  OPC_SUB   = 7'b0110010;
  localparam logic [31:0] NOP_INSTR = {5'b11001, 27'b0};

  typedef enum logic [1:0] {
    OP_MUL = 2'b00,
    OP_MAC = 2'b01,
    OP_CLR = 2'b10,
    OP_RSV = 2'b11
  } op_t;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_CLR  = 3'd1,
    ST_MOV  = 3'd2,
    ST_ADD  = 3'd3,
    ST_FIN  = 3'd4
  } state_t;

  // SUB Rd,Rd,Rd -- clears the destination register.
  function automatic logic [31:0] fmt_sub(input logic [3:0] rd);
    return {OPC_SUB, rd, rd, rd, 13'b0};
  endfunction

  // MOV Rd,#0 -- seeds the accumulator before the ADD chain.
  function automatic logic [31:0] fmt_mov(input logic [3:0] rd);
    return {OPC_MOV, rd, 5'b0, 16'b0};
  endfunction

  // ADD Rd,Rd,Rs -- one step of the repeated-add multiply.
  function automatic logic [31:0] fmt_add(input logic [3:0] rd, input logic [3:0] rs);
    return {OPC_ADD, rd, rd, rs, 13'b0};
  endfunction

endpackage

// File: rtl/ucode_seq.sv
// ucode_seq -- expands MUL / MAC / CLR macro-ops into a stream of
// MOV / ADD / SUB micro-instructions.
//
// Handshakes (both sides): a transfer happens on a rising clk edge where
// valid && ready are both high. Once out_valid is raised it stays high with
// out_instr unchanged until the transfer; start_ready is high only in IDLE.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   start_valid/ready   macro-op handshake from the decoder
//   op_sel              00 MUL, 01 MAC, 10 CLR, 11 reserved
//   dest_reg/source_reg Rd / Rs addresses (latched on accept)
//   immediate           repeat count (latched on accept)
//   out_instr/valid/ready  generated instruction stream; NOP when not valid
//   busy                high outside IDLE
//   done, err           one-cycle completion pulse; err flags a reserved op
//   abort               flush request, honoured only when UCODE_ABORT_EN is
//                       defined; otherwise the port exists but is ignored
//
// Debug: the FSM state is held in state_q (type state_t) for checkers.
module ucode_seq
  import ucode_pkg::*;
#(
  parameter int IMM_W   = 16,
  parameter int INSTR_W = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_valid,
  output logic               start_ready,
  input  logic [1:0]         op_sel,
  input  logic [3:0]         dest_reg,
  input  logic [3:0]         source_reg,
  input  logic [IMM_W-1:0]   immediate,
  output logic [INSTR_W-1:0] out_instr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               busy,
  output logic               done,
  output logic               err,
  input  logic               abort
);

  state_t           state_q, state_d;
  logic [IMM_W-1:0] cnt_q, cnt_d;
  op_t              op_q;
  logic [3:0]       rd_q, rs_q;
  logic             accept;

`ifndef UCODE_ABORT_EN
  logic unused_abort;
  assign unused_abort = abort;
`endif

  assign start_ready = (state_q == ST_IDLE);
  assign busy        = (state_q != ST_IDLE);
  assign accept      = start_valid && start_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      op_q    <= OP_MUL;
      rd_q    <= '0;
      rs_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        op_q <= op_t'(op_sel);
        rd_q <= dest_reg;
        rs_q <= source_reg;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    out_valid = 1'b0;
    out_instr = NOP_INSTR;
    done      = 1'b0;
    err       = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          cnt_d = immediate;
          case (op_t'(op_sel))
            OP_MUL:  state_d = (immediate == '0) ? ST_CLR : ST_MOV;
            OP_MAC:  state_d = (immediate == '0) ? ST_FIN : ST_ADD;
            OP_CLR:  state_d = ST_CLR;
            default: state_d = ST_FIN;
          endcase
        end
      end
      ST_CLR: begin
        out_valid = 1'b1;
        out_instr = fmt_sub(rd_q);
        if (out_ready) state_d = ST_FIN;
      end
      ST_MOV: begin
        out_valid = 1'b1;
        out_instr = fmt_mov(rd_q);
        if (out_ready) state_d = ST_ADD;
      end
      ST_ADD: begin
        out_valid = 1'b1;
        out_instr = fmt_add(rd_q, rs_q);
        if (out_ready) begin
          // Counter holds the ADDs still to issue, including this one.
          cnt_d = cnt_q - IMM_W'(1);
          if (cnt_q == IMM_W'(1)) state_d = ST_FIN;
        end
      end
      ST_FIN: begin
        done    = 1'b1;
        err     = (op_q == OP_RSV);
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

`ifdef UCODE_ABORT_EN
    // Abort wins over any handshake: nothing is transferred this cycle.
    if (abort) begin
      state_d   = ST_IDLE;
      cnt_d     = '0;
      out_valid = 1'b0;
      out_instr = NOP_INSTR;
      done      = 1'b0;
      err       = 1'b0;
    end
`endif
  end

endmodule

// File: tb/tb_ucode_seq.sv
module tb_ucode_seq;
  localparam int IMM_W = 16;
  localparam logic [31:0] NOP_W = 32'hC800_0000;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start_valid = 1'b0;
  logic             out_ready = 1'b0;
  logic             abort = 1'b0;
  logic [1:0]       op_sel = '0;
  logic [3:0]       dest_reg = '0;
  logic [3:0]       source_reg = '0;
  logic [IMM_W-1:0] immediate = '0;
  logic             start_ready, out_valid, busy, done, err;
  logic [31:0]      out_instr;

  int n_checks = 0;
  int n_fail = 0;
  logic [31:0] exp_q[$];

  // clock / reset block
  always #5 clk = ~clk;

  ucode_seq #(.IMM_W(IMM_W), .INSTR_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .start_valid(start_valid), .start_ready(start_ready),
    .op_sel(op_sel), .dest_reg(dest_reg), .source_reg(source_reg),
    .immediate(immediate),
    .out_instr(out_instr), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .done(done), .err(err), .abort(abort)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: instruction words built with plain arithmetic.
  function automatic logic [31:0] enc(input longint opc, input longint a,
                                      input longint b, input longint c);
    longint w;
    w = opc * (64'd1 << 25) + a * (64'd1 << 21) + b * (64'd1 << 17) + c * (64'd1 << 13);
    return w[31:0];
  endfunction

  task automatic model(input int op, input int rd, input int rs, input int imm,
                       output bit e);
    exp_q.delete();
    e = 1'b0;
    case (op)
      0: begin
        if (imm == 0) exp_q.push_back(enc(50, rd, rd, rd));
        else begin
          exp_q.push_back(enc(0, rd, 0, 0));
          repeat (imm) exp_q.push_back(enc(49, rd, rd, rs));
        end
      end
      1: repeat (imm) exp_q.push_back(enc(49, rd, rd, rs));
      2: exp_q.push_back(enc(50, rd, rd, rd));
      default: e = 1'b1;
    endcase
  endtask

  // Driver + scoreboard for one macro-op. Inputs change on negedge, outputs
  // are sampled 1ns later; k counts cycles after the accept edge.
  task automatic run_txn(input int op, input int rd, input int rs, input int imm,
                         input bit rnd, input int stall_lo, input int abort_at,
                         input int rst_at);
    bit e, seen_done, prev_stall;
    int k, stalls, issued, len, limit;
    logic [31:0] prev_instr;
    model(op, rd, rs, imm, e);
    len = exp_q.size();
    limit = 4 * len + 100;
    @(negedge clk);
    op_sel = 2'(op); dest_reg = 4'(rd); source_reg = 4'(rs);
    immediate = IMM_W'(imm); start_valid = 1'b1; out_ready = 1'b0; abort = 1'b0;
    #1 check("start_ready_idle", 32'(start_ready), 32'd1);
    k = 0; stalls = 0; issued = 0; seen_done = 0; prev_stall = 0; prev_instr = '0;
    while (!seen_done && k < limit) begin
      @(negedge clk);
      k++;
      start_valid = 1'b0;
      op_sel = 2'($urandom); dest_reg = 4'($urandom); source_reg = 4'($urandom);
      immediate = IMM_W'($urandom);
      out_ready = (k <= stall_lo) ? 1'b0 : (rnd ? 1'($urandom_range(0, 1)) : 1'b1);
      abort = (k == abort_at);
      if (k == rst_at) rst_n = 1'b0;
      #1;
      if (k == rst_at) begin
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_instr", out_instr, NOP_W);
        check("rst_start_ready", 32'(start_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1; out_ready = 1'b1;
        #1 check("rst_no_done_1", 32'(done), 32'd0);
        @(negedge clk);
        #1 check("rst_no_done_2", 32'(done), 32'd0);
        check("rst_idle", 32'(start_ready), 32'd1);
        exp_q.delete();
        return;
      end
`ifdef UCODE_ABORT_EN
      if (k == abort_at) begin
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_out_instr", out_instr, NOP_W);
        check("abort_done", 32'(done), 32'd0);
        @(negedge clk);
        abort = 1'b0;
        #1 check("abort_idle", 32'(start_ready), 32'd1);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_no_done", 32'(done), 32'd0);
        exp_q.delete();
        return;
      end
`endif
      if (prev_stall) begin
        check("hold_valid", 32'(out_valid), 32'd1);
        check("hold_instr", out_instr, prev_instr);
      end
      if (!out_valid) check("nop_when_invalid", out_instr, NOP_W);
      check("busy", 32'(busy), 32'd1);
      check("start_ready_busy", 32'(start_ready), 32'd0);
      if (out_valid && out_ready) begin
        issued++;
        if (exp_q.size() > 0) check("instr", out_instr, exp_q.pop_front());
      end
      prev_stall = out_valid && !out_ready;
      prev_instr = out_instr;
      if (prev_stall) stalls++;
      if (done) begin
        seen_done = 1'b1;
        check("done_cycle", 32'(k), 32'(len + 1 + stalls));
        check("err", 32'(err), 32'(e));
        check("issued", 32'(issued), 32'(len));
      end else begin
        check("err_low", 32'(err), 32'd0);
      end
    end
    if (!seen_done) check("done_timeout", 32'(seen_done), 32'd1);
    @(negedge clk);
    abort = 1'b0; out_ready = 1'b0;
    #1 check("post_done", 32'(done), 32'd0);
    check("post_busy", 32'(busy), 32'd0);
    check("post_start_ready", 32'(start_ready), 32'd1);
    check("post_out_valid", 32'(out_valid), 32'd0);
    check("post_out_instr", out_instr, NOP_W);
  endtask

  initial begin
    // reset state
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("reset_start_ready", 32'(start_ready), 32'd1);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_out_instr", out_instr, NOP_W);
    check("reset_done", 32'(done), 32'd0);
    check("reset_err", 32'(err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // MUL R1,R0,#3: MOV then three ADDs, done at accept+5
    run_txn(0, 1, 0, 3, 1'b0, 0, -1, -1);
    // MUL imm=0, CLR op, MAC imm=0
    run_txn(0, 1, 0, 0, 1'b0, 0, -1, -1);
    run_txn(2, 1, 5, 7, 1'b0, 0, -1, -1);
    run_txn(1, 4, 6, 0, 1'b0, 0, -1, -1);
    // MAC R2,R3,#2 with a 3-cycle stall on the first ADD
    run_txn(1, 2, 3, 2, 1'b0, 3, -1, -1);
    // reserved op
    run_txn(3, 7, 8, 4, 1'b0, 0, -1, -1);
    // reset during the 2nd ADD of imm=5
    run_txn(0, 9, 10, 5, 1'b0, 0, -1, 3);
    // abort while in MOV
    run_txn(0, 11, 12, 2, 1'b0, 0, 1, -1);
    // randomized macro-ops with random back-pressure
    for (int i = 0; i < 30; i++)
      run_txn(int'($urandom_range(0, 3)), int'($urandom_range(0, 15)),
              int'($urandom_range(0, 15)), int'($urandom_range(0, 6)),
              1'b1, int'($urandom_range(0, 2)), -1, -1);
    // full-range repeat count
    run_txn(0, 15, 14, 65535, 1'b0, 0, -1, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
